instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Converts structured instruction requests (op, rd, rs1, rs2, imm) into RV32I machine words and writes them to sequential instruction-memory addresses.
- It is the inverse of the core's opcode/funct3/funct7 decoder and supports the same instruction subset.
- Sits between the boot/test host and instruction memory, and holds the core idle until the program load is complete.

Parameters:
- ADDR_W, 8, word-address width of instruction memory.
- DEPTH, 64, number of loadable words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  loader can accept a request.
- req_op  input  5  operation code (enc_op_t).
- req_rd  input  5  destination register.
- req_rs1  input  5  source register 1.
- req_rs2  input  5  source register 2.
- req_imm  input  32  signed immediate or byte offset.
- req_last  input  1  final instruction of the program.
- restart  input  1  in DONE, starts a new load.
- imem_wr_en  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wr_data  output  32  encoded instruction.
- load_done  output  1  program loaded.
- core_hold  output  1  keeps the core stalled while loading.
- err_illegal  output  1  sticky error: an illegal request was dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, wr_ptr=0, req_ready=1, imem_wr_en=0, imem_addr=0, imem_wr_data=0, load_done=0, core_hold=1, err_illegal=0.
- FSM states:
  - IDLE: req_ready=1.
  - WRITE: req_ready=0.
  - DONE: req_ready=0, load_done=1, core_hold=0.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. Outputs are registered, so the encoded word and address appear, with imem_wr_en=1, for exactly one cycle after acceptance. Sustained throughput is 1 word per 2 cycles.
- Transitions on accept of a legal request:
  - IDLE -> WRITE.
  - After the write, wr_ptr increments.
  - WRITE -> DONE if req_last was set or wr_ptr was DEPTH-1; otherwise WRITE -> IDLE.
- Illegal request: no write, wr_ptr unchanged, err_illegal set, state stays IDLE. If req_last was also set, go to DONE. A request is illegal when any of the following holds:
  - undefined op;
  - I-type imm outside -2048..2047;
  - B imm outside -4096..4094 or odd;
  - J imm outside +/-1 MiB or odd.
- Encoding:
  - R (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND): funct7|rs2|rs1|funct3|rd|0110011. funct7=0100000 for SUB/SRA, else 0.
  - I (ADDI,SLTI,SLTIU,XORI,ORI,ANDI): imm[11:0]|rs1|funct3|rd|0010011.
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Unused fields in the request are ignored.
- DONE:
  - restart=1 -> IDLE, wr_ptr=0, err_illegal=0, load_done=0, core_hold=1.
  - restart is ignored in IDLE and WRITE.
  - req_valid is ignored in DONE.
- Reset mid-WRITE: the write strobe drops immediately and asynchronously; the memory word at that address is undefined.

Optional Feature:
- ENC_NOP_PAD_EN defined: after the final write, the FSM enters PAD. In PAD it writes NOP 0x00000013 to every remaining address up to DEPTH-1, one per cycle, then goes to DONE; core_hold stays 1 throughout PAD.
- Undefined: the FSM goes directly to DONE, and remaining words are untouched.

Decomposition:
- Package rv_enc_pkg holds:
  - enc_op_t enum;
  - opcode constants (0110011, 0010011, 1100011, 1101111);
  - funct3/funct7 constants, bit-identical to those used by the control-unit decoder;
  - NOP_WORD;
  - immediate range limits.
- Sub-module instr_word_encoder: purely combinational, maps op/regs/imm to {word, illegal}. The FSM, pointer and output registers stay in the top.

Test Plan:
- ADDI x1,x0,1 -> one cycle later imem_wr_en=1, addr=0, data=0x00100093; wr_ptr becomes 1.
- ADD x3,x1,x2 then SUB x3,x1,x2 -> 0x002081B3 at addr 0, 0x402081B3 at addr 1; req_ready low during each WRITE cycle.
- BEQ x0,x0,-8 -> 0xFE000CE3. JAL x1,8 (req_last=1) -> 0x008000EF, then load_done=1, core_hold=0.
- ADDI imm=2048, then BEQ imm=3 -> no imem_wr_en, err_illegal=1, addr unchanged. restart after DONE clears err_illegal and wr_ptr.
- DEPTH=4, five requests without req_last -> four writes (addr 0..3), DONE after the 4th, and the 5th request is never accepted. With ENC_NOP_PAD_EN and req_last at addr 1 -> 0x00000013 written at addr 2 and 3 before load_done.
- rst_n low during WRITE -> imem_wr_en=0 asynchronously; after release, req_ready=1 and addr=0.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared encodings for the RV32I instruction loader: request op codes, opcode/funct fields,
// immediate range limits and loader FSM states.
package rv_enc_pkg;

    typedef enum logic [4:0] {
        OpAdd   = 5'd0,
        OpSub   = 5'd1,
        OpSll   = 5'd2,
        OpSlt   = 5'd3,
        OpSltu  = 5'd4,
        OpXor   = 5'd5,
        OpSrl   = 5'd6,
        OpSra   = 5'd7,
        OpOr    = 5'd8,
        OpAnd   = 5'd9,
        OpAddi  = 5'd10,
        OpSlti  = 5'd11,
        OpSltiu = 5'd12,
        OpXori  = 5'd13,
        OpOri   = 5'd14,
        OpAndi  = 5'd15,
        OpBeq   = 5'd16,
        OpJal   = 5'd17
    } enc_op_t;

    typedef enum logic [2:0] {FmtR, FmtI, FmtB, FmtJ, FmtBad} enc_fmt_e;

    typedef enum logic [1:0] {StIdle, StWrite, StPad, StDone} loader_state_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Beq    = 3'b000;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [31:0] NopWord = 32'h0000_0013;

    localparam int ImmIMin = -2048;
    localparam int ImmIMax = 2047;
    localparam int ImmBMin = -4096;
    localparam int ImmBMax = 4094;
    localparam int ImmJMin = -1048576;
    localparam int ImmJMax = 1048574;

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational RV32I encoder: request fields to machine word plus an illegal flag.
module instr_word_encoder
    import rv_enc_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    enc_fmt_e           fmt;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] simm;

    assign simm = imm_i;

    always_comb begin
        fmt = FmtBad;
        f3  = 3'b000;
        f7  = F7Base;
        case (op_i)
            OpAdd:   begin fmt = FmtR; f3 = F3AddSub; end
            OpSub:   begin fmt = FmtR; f3 = F3AddSub; f7 = F7Alt; end
            OpSll:   begin fmt = FmtR; f3 = F3Sll;    end
            OpSlt:   begin fmt = FmtR; f3 = F3Slt;    end
            OpSltu:  begin fmt = FmtR; f3 = F3Sltu;   end
            OpXor:   begin fmt = FmtR; f3 = F3Xor;    end
            OpSrl:   begin fmt = FmtR; f3 = F3SrlSra; end
            OpSra:   begin fmt = FmtR; f3 = F3SrlSra; f7 = F7Alt; end
            OpOr:    begin fmt = FmtR; f3 = F3Or;     end
            OpAnd:   begin fmt = FmtR; f3 = F3And;    end
            OpAddi:  begin fmt = FmtI; f3 = F3AddSub; end
            OpSlti:  begin fmt = FmtI; f3 = F3Slt;    end
            OpSltiu: begin fmt = FmtI; f3 = F3Sltu;   end
            OpXori:  begin fmt = FmtI; f3 = F3Xor;    end
            OpOri:   begin fmt = FmtI; f3 = F3Or;     end
            OpAndi:  begin fmt = FmtI; f3 = F3And;    end
            OpBeq:   begin fmt = FmtB; f3 = F3Beq;    end
            OpJal:   begin fmt = FmtJ; end
            default: fmt = FmtBad;
        endcase
    end

    always_comb begin
        word_o    = 32'h0;
        illegal_o = 1'b0;
        unique case (fmt)
            FmtR: word_o = {f7, rs2_i, rs1_i, f3, rd_i, OpcOp};
            FmtI: begin
                word_o    = {imm_i[11:0], rs1_i, f3, rd_i, OpcOpImm};
                illegal_o = (simm < ImmIMin) || (simm > ImmIMax);
            end
            FmtB: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11],
                             OpcBranch};
                illegal_o = (simm < ImmBMin) || (simm > ImmBMax) || imm_i[0];
            end
            FmtJ: begin
                word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OpcJal};
                illegal_o = (simm < ImmJMin) || (simm > ImmJMax) || imm_i[0];
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests and writes them to sequential imem addresses, holding the core
// until loading finishes. Define ENC_NOP_PAD_EN to fill unused words with NOPs after the last.
module instr_encoder_loader
    import rv_enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              req_last,
    input  logic              restart,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wr_data,
    output logic              load_done,
    output logic              core_hold,
    output logic              err_illegal
);

    // One extra pointer bit lets the pad loop observe "all DEPTH words written".
    localparam int unsigned   PtrW     = ADDR_W + 1;
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
    localparam logic [PtrW-1:0] DepthPtr = PtrW'(DEPTH);

    loader_state_e     state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic              last_q, last_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [31:0]       enc_word;
    logic              enc_illegal;

    instr_word_encoder u_encoder (
        .op_i      (req_op),
        .rd_i      (req_rd),
        .rs1_i     (req_rs1),
        .rs2_i     (req_rs2),
        .imm_i     (req_imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        last_d   = last_q;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (enc_illegal) begin
                        err_d = 1'b1;
                        if (req_last) state_d = StDone;
                    end else begin
                        state_d = StWrite;
                        wr_en_d = 1'b1;
                        addr_d  = wr_ptr_q[ADDR_W-1:0];
                        data_d  = enc_word;
                        last_d  = req_last;
                    end
                end
            end
            StWrite: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == LastPtr) begin
                    state_d = StDone;
                end else if (last_q) begin
`ifdef ENC_NOP_PAD_EN
                    state_d = StPad;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StPad: begin
                if (wr_ptr_q < DepthPtr) begin
                    wr_en_d  = 1'b1;
                    addr_d   = wr_ptr_q[ADDR_W-1:0];
                    data_d   = NopWord;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (restart) begin
                    state_d  = StIdle;
                    wr_ptr_d = '0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            last_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            last_q   <= last_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign load_done    = (state_q == StDone);
    assign core_hold    = (state_q != StDone);
    assign imem_wr_en   = wr_en_q;
    assign imem_addr    = addr_q;
    assign imem_wr_data = data_q;
    assign err_illegal  = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4), with NOP-pad checks when
// ENC_NOP_PAD_EN is defined.
module tb_instr_encoder_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              req_last;
    logic              restart;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wr_data;
    logic              load_done;
    logic              core_hold;
    logic              err_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .req_last     (req_last),
        .restart      (restart),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .load_done    (load_done),
        .core_hold    (core_hold),
        .err_illegal  (err_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits (bounded) for ready, returns #1 after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        int n;
        @(negedge clk);
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        req_last  = last;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [7:0] addr, input logic [31:0] data);
        chk({tag, "_wr_en"}, {31'b0, imem_wr_en}, 32'd1);
        chk({tag, "_addr"}, {24'b0, imem_addr}, {24'b0, addr});
        chk({tag, "_data"}, imem_wr_data, data);
        chk({tag, "_ready_low"}, {31'b0, req_ready}, 32'd0);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 5'd0;
        req_rd    = 5'd0;
        req_rs1   = 5'd0;
        req_rs2   = 5'd0;
        req_imm   = 32'd0;
        req_last  = 1'b0;
        restart   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_wr_en", {31'b0, imem_wr_en}, 32'd0);
        chk("rst_addr", {24'b0, imem_addr}, 32'd0);
        chk("rst_data", imem_wr_data, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_hold", {31'b0, core_hold}, 32'd1);
        chk("rst_err", {31'b0, err_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Phase A: ADDI, ADD, two illegal requests, JAL with last.
        send(5'd10, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        chk_write("addi", 8'd0, 32'h0010_0093);
        step();
        chk("addi_wr_drop", {31'b0, imem_wr_en}, 32'd0);
        chk("addi_ready_back", {31'b0, req_ready}, 32'd1);

        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk_write("add", 8'd1, 32'h0020_81B3);
        step();

        send(5'd10, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        chk("ill_addi_wr_en", {31'b0, imem_wr_en}, 32'd0);
        chk("ill_addi_err", {31'b0, err_illegal}, 32'd1);
        chk("ill_addi_addr", {24'b0, imem_addr}, 32'd1);
        chk("ill_addi_ready", {31'b0, req_ready}, 32'd1);

        send(5'd16, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0);
        chk("ill_beq_wr_en", {31'b0, imem_wr_en}, 32'd0);
        chk("ill_beq_addr", {24'b0, imem_addr}, 32'd1);

        send(5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        chk("ill_op_wr_en", {31'b0, imem_wr_en}, 32'd0);

        send(5'd17, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        chk_write("jal", 8'd2, 32'h0080_00EF);
        step();
`ifdef ENC_NOP_PAD_EN
        chk("pad_hold", {31'b0, core_hold}, 32'd1);
        chk("pad_not_done", {31'b0, load_done}, 32'd0);
        step();
        chk_write("pad", 8'd3, 32'h0000_0013);
        chk("pad_hold2", {31'b0, core_hold}, 32'd1);
        step();
`endif
        chk("a_done", {31'b0, load_done}, 32'd1);
        chk("a_hold", {31'b0, core_hold}, 32'd0);
        chk("a_err_sticky", {31'b0, err_illegal}, 32'd1);
        chk("a_ready_low", {31'b0, req_ready}, 32'd0);

        do_restart();
        chk("restart_done", {31'b0, load_done}, 32'd0);
        chk("restart_hold", {31'b0, core_hold}, 32'd1);
        chk("restart_err", {31'b0, err_illegal}, 32'd0);
        chk("restart_ready", {31'b0, req_ready}, 32'd1);

        // restart in IDLE must have no effect.
        do_restart();
        chk("idle_restart_ready", {31'b0, req_ready}, 32'd1);

        // Phase B: fill all four words without req_last.
        send(5'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk_write("sub", 8'd0, 32'h4020_81B3);
        step();
        send(5'd16, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b0);
        chk_write("beq", 8'd1, 32'hFE00_0CE3);
        step();
        send(5'd7, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
        chk_write("sra", 8'd2, 32'h4062_D233);
        step();
        send(5'd13, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, 1'b0);
        chk_write("xori", 8'd3, 32'hFFF3_4293);
        step();
        chk("full_done", {31'b0, load_done}, 32'd1);

        // Fifth request must be ignored while DONE.
        @(negedge clk);
        req_op    = 5'd10;
        req_imm   = 32'd5;
        req_valid = 1'b1;
        step();
        chk("fifth_wr_en", {31'b0, imem_wr_en}, 32'd0);
        step();
        chk("fifth_ready", {31'b0, req_ready}, 32'd0);
        chk("fifth_addr", {24'b0, imem_addr}, 32'd3);
        chk("fifth_done", {31'b0, load_done}, 32'd1);
        req_valid = 1'b0;

        // Phase C: asynchronous reset during WRITE.
        do_restart();
        send(5'd10, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        chk("prerst_wr_en", {31'b0, imem_wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", {31'b0, imem_wr_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_addr", {24'b0, imem_addr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
